// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage core, tracking shadow E/M/W stages.
// Define HAZ_MULTICYCLE_EN to enable multi-cycle EX operations (busy_o, occupancy counter).

module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              id_multi_i,
    input  logic              id_branch_i,
    input  logic              br_taken_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              ex_mem_bubble_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              fwd_br_a_o,
    output logic              fwd_br_b_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
        logic              multi;
    } stage_t;

    function automatic stage_t make_bubble(input stage_t s);
        stage_t b;
        b          = s;
        b.regwrite = 1'b0;
        b.memread  = 1'b0;
        b.multi    = 1'b0;
        return b;
    endfunction

    function automatic logic hits(input stage_t s, input logic [REG_AW-1:0] src, input logic used);
        return used && s.regwrite && (s.rd != '0) && (s.rd == src);
    endfunction

    stage_t           e_q, e_d, m_q, m_d, w_q, w_d, id_stage;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             rs1_used, rs2_used;
    logic             e_hit_id, m_hit_id;
    logic             load_use, br_stall, stall, busy, hold, multi_in;

    assign rs1_used = id_valid_i & id_use_rs1_i;
    assign rs2_used = id_valid_i & id_use_rs2_i;

    // Unused sources are stored as x0 so they can never match a producer later.
    always_comb begin
        id_stage          = '0;
        id_stage.rs1      = rs1_used ? id_rs1_i : '0;
        id_stage.rs2      = rs2_used ? id_rs2_i : '0;
        id_stage.rd       = id_rd_i;
        id_stage.regwrite = id_valid_i & id_regwrite_i;
        id_stage.memread  = id_valid_i & id_memread_i;
        id_stage.multi    = id_valid_i & multi_in;
    end

    assign e_hit_id = hits(e_q, id_rs1_i, rs1_used) | hits(e_q, id_rs2_i, rs2_used);
    assign m_hit_id = hits(m_q, id_rs1_i, rs1_used) | hits(m_q, id_rs2_i, rs2_used);
    assign load_use = e_q.memread & e_hit_id;
    assign br_stall = id_branch_i & (e_hit_id | (m_q.memread & m_hit_id));
    assign stall    = ~busy & (load_use | br_stall);
    assign hold     = busy | stall;

`ifdef HAZ_MULTICYCLE_EN
    localparam int              MC_W    = $clog2(MUL_LAT);
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MUL_LAT - 1);

    logic [MC_W-1:0] cnt_q, cnt_d;

    assign busy     = (cnt_q != '0);
    assign multi_in = id_multi_i;

    // The counter is armed on the edge that loads a multi-cycle op into E.
    always_comb begin
        cnt_d = cnt_q;
        if (busy) begin
            cnt_d = cnt_q - MC_W'(1);
        end else if (!stall && id_stage.multi) begin
            cnt_d = MC_LOAD;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_cfg;

    assign busy       = 1'b0;
    assign multi_in   = 1'b0;
    assign unused_cfg = id_multi_i ^ (MUL_LAT < 2);
`endif

    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = m_q;
        if (busy) begin
            m_d = make_bubble(e_q);
        end else if (stall) begin
            e_d = make_bubble(e_q);
            m_d = e_q;
        end else begin
            e_d = id_stage;
            m_d = e_q;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            e_q         <= '0;
            m_q         <= '0;
            w_q         <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            w_q         <= w_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // EX/MEM has priority over MEM/WB since it holds the younger result.
    always_comb begin
        fwd_a_o = 2'b00;
        fwd_b_o = 2'b00;
        if (hits(m_q, e_q.rs1, 1'b1)) begin
            fwd_a_o = 2'b10;
        end else if (hits(w_q, e_q.rs1, 1'b1)) begin
            fwd_a_o = 2'b01;
        end
        if (hits(m_q, e_q.rs2, 1'b1)) begin
            fwd_b_o = 2'b10;
        end else if (hits(w_q, e_q.rs2, 1'b1)) begin
            fwd_b_o = 2'b01;
        end
    end

    logic unused_w;
    assign unused_w = ^{w_q.rs1, w_q.rs2, w_q.memread, w_q.multi};

    assign pc_write_o      = ~hold;
    assign if_id_write_o   = ~hold;
    assign id_ex_bubble_o  = stall;
    assign ex_mem_bubble_o = busy;
    assign if_id_flush_o   = id_branch_i & br_taken_i & ~hold;
    assign fwd_br_a_o      = hits(m_q, id_rs1_i, rs1_used) & ~m_q.memread;
    assign fwd_br_b_o      = hits(m_q, id_rs2_i, rs2_used) & ~m_q.memread;
    assign busy_o          = busy;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed pipeline scenarios plus random instruction
// streams checked against an instruction-level model of the pipeline.

module tb_pipe_hazard_ctrl;

    localparam int REG_AW  = 5;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 16;
`ifdef HAZ_MULTICYCLE_EN
    localparam bit MC = 1'b1;
`else
    localparam bit MC = 1'b0;
`endif

    logic              clk_i, rst_n_i;
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
    logic              id_use_rs1_i, id_use_rs2_i;
    logic              id_regwrite_i, id_memread_i, id_multi_i, id_branch_i, br_taken_i;
    logic              pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o, ex_mem_bubble_o;
    logic [1:0]        fwd_a_o, fwd_b_o;
    logic              fwd_br_a_o, fwd_br_b_o, busy_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .id_valid_i(id_valid_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
        .id_multi_i(id_multi_i), .id_branch_i(id_branch_i), .br_taken_i(br_taken_i),
        .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_bubble_o(id_ex_bubble_o), .ex_mem_bubble_o(ex_mem_bubble_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .fwd_br_a_o(fwd_br_a_o), .fwd_br_b_o(fwd_br_b_o),
        .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // An in-flight instruction: sources are -1 when not read.
    typedef struct {
        int rs1;
        int rs2;
        int rd;
        bit wr;
        bit ld;
        bit mul;
    } ins_t;

    ins_t me, mm, mw;
    int   rem, sc, s1, s2;
    bit   m_stall;
    bit   e_pcw, e_flush, e_idb, e_exb, e_busy, e_fba, e_fbb;
    int   e_fa, e_fb, e_sc;

    function automatic bit writes(input ins_t p, input int r);
        return p.wr && (p.rd != 0) && (p.rd == r);
    endfunction

    task automatic model_reset();
        me  = '{rs1: -1, rs2: -1, rd: 0, wr: 0, ld: 0, mul: 0};
        mm  = me;
        mw  = me;
        rem = 0;
        sc  = 0;
    endtask

    task automatic model_eval();
        bit lu, br;
        s1      = (id_valid_i && id_use_rs1_i) ? int'(id_rs1_i) : -1;
        s2      = (id_valid_i && id_use_rs2_i) ? int'(id_rs2_i) : -1;
        e_busy  = (rem > 0);
        lu      = me.ld && (writes(me, s1) || writes(me, s2));
        br      = id_branch_i && (writes(me, s1) || writes(me, s2) ||
                  (mm.ld && (writes(mm, s1) || writes(mm, s2))));
        m_stall = !e_busy && (lu || br);
        e_pcw   = !(e_busy || m_stall);
        e_idb   = m_stall;
        e_exb   = e_busy;
        e_flush = id_branch_i && br_taken_i && e_pcw;
        e_fa    = writes(mm, me.rs1) ? 2 : (writes(mw, me.rs1) ? 1 : 0);
        e_fb    = writes(mm, me.rs2) ? 2 : (writes(mw, me.rs2) ? 1 : 0);
        e_fba   = writes(mm, s1) && !mm.ld;
        e_fbb   = writes(mm, s2) && !mm.ld;
        e_sc    = sc;
    endtask

    task automatic model_advance();
        if (!e_pcw && sc < (1 << CNT_W) - 1) sc++;
        mw = mm;
        if (e_busy) begin
            mm = me;
            mm.wr = 0; mm.ld = 0; mm.mul = 0;
            rem--;
        end else if (m_stall) begin
            mm = me;
            me.wr = 0; me.ld = 0; me.mul = 0;
        end else begin
            mm = me;
            if (id_valid_i) begin
                me = '{rs1: s1, rs2: s2, rd: int'(id_rd_i), wr: id_regwrite_i,
                       ld: id_memread_i, mul: id_multi_i && MC};
                if (MC && id_multi_i) rem = MUL_LAT - 1;
            end else begin
                me = '{rs1: -1, rs2: -1, rd: 0, wr: 0, ld: 0, mul: 0};
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int v, input int rs1, input int u1, input int rs2, input int u2,
                         input int rd, input int wr, input int ld, input int mul,
                         input int br, input int tk);
        id_valid_i    = 1'(v);
        id_rs1_i      = REG_AW'(rs1);
        id_use_rs1_i  = 1'(u1);
        id_rs2_i      = REG_AW'(rs2);
        id_use_rs2_i  = 1'(u2);
        id_rd_i       = REG_AW'(rd);
        id_regwrite_i = 1'(wr);
        id_memread_i  = 1'(ld);
        id_multi_i    = 1'(mul);
        id_branch_i   = 1'(br);
        br_taken_i    = 1'(tk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample();
        @(negedge clk_i);
        model_eval();
    endtask

    task automatic step();
        model_advance();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_n_i = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        rst_n_i = 1'b0;
        #3;
        n_vec++; if (pc_write_o !== 1'b1) begin n_err++; $display("FAIL reset_pc_write: got %0b want 1", pc_write_o); end
        n_vec++; if (if_id_write_o !== 1'b1) begin n_err++; $display("FAIL reset_if_id_write: got %0b want 1", if_id_write_o); end
        n_vec++; if (if_id_flush_o !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %0b want 0", if_id_flush_o); end
        n_vec++; if (id_ex_bubble_o !== 1'b0) begin n_err++; $display("FAIL reset_id_ex_bubble: got %0b want 0", id_ex_bubble_o); end
        n_vec++; if (ex_mem_bubble_o !== 1'b0) begin n_err++; $display("FAIL reset_ex_mem_bubble: got %0b want 0", ex_mem_bubble_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy_o); end
        n_vec++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin n_err++; $display("FAIL reset_fwd: got %b/%b want 00/00", fwd_a_o, fwd_b_o); end
        n_vec++; if (fwd_br_a_o !== 1'b0 || fwd_br_b_o !== 1'b0) begin n_err++; $display("FAIL reset_fwd_br: got %b/%b want 0/0", fwd_br_a_o, fwd_br_b_o); end
        n_vec++; if (stall_cnt_o !== '0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt_o); end
        apply_reset();
    endtask

    task automatic test_forwarding();
        apply_reset();
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0);            // add x5,x1,x2
        sample(); step();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);            // add x6,x5,x1
        sample();
        n_vec++; if (pc_write_o !== 1'b1) begin n_err++; $display("FAIL fwd_no_stall: got %0b want 1", pc_write_o); end
        step(); idle(); sample();
        n_vec++; if (fwd_a_o !== 2'b10) begin n_err++; $display("FAIL fwd_a_exmem: got %b want 10", fwd_a_o); end
        n_vec++; if (fwd_b_o !== 2'b00) begin n_err++; $display("FAIL fwd_b_none: got %b want 00", fwd_b_o); end
        step();
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0);
        sample(); step();
        idle(); sample(); step();
        drive(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);
        sample(); step();
        idle(); sample();
        n_vec++; if (fwd_a_o !== 2'b01) begin n_err++; $display("FAIL fwd_a_memwb: got %b want 01", fwd_a_o); end
        n_vec++; if (stall_cnt_o !== 16'd0) begin n_err++; $display("FAIL fwd_stall_cnt: got %0d want 0", stall_cnt_o); end
        step();
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(1, 3, 1, 0, 0, 5, 1, 1, 0, 0, 0);            // lw x5,0(x3)
        sample(); step();
        drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0);            // add x6,x5,x5
        sample();
        n_vec++; if (pc_write_o !== 1'b0 || if_id_write_o !== 1'b0) begin n_err++; $display("FAIL lu_hold: got pc=%0b ifid=%0b want 0/0", pc_write_o, if_id_write_o); end
        n_vec++; if (id_ex_bubble_o !== 1'b1) begin n_err++; $display("FAIL lu_bubble: got %0b want 1", id_ex_bubble_o); end
        step(); sample();
        n_vec++; if (pc_write_o !== 1'b1) begin n_err++; $display("FAIL lu_release: got %0b want 1", pc_write_o); end
        step(); idle(); sample();
        n_vec++; if (fwd_a_o !== 2'b01 || fwd_b_o !== 2'b01) begin n_err++; $display("FAIL lu_fwd: got %b/%b want 01/01", fwd_a_o, fwd_b_o); end
        n_vec++; if (stall_cnt_o !== 16'd1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt_o); end
        step();
    endtask

    task automatic test_branch();
        apply_reset();
        drive(1, 1, 1, 2, 1, 7, 1, 0, 0, 0, 0);            // add x7,x1,x2
        sample(); step();
        drive(1, 7, 1, 0, 1, 0, 0, 0, 0, 1, 1);            // beq x7,x0 taken
        sample();
        n_vec++; if (pc_write_o !== 1'b0 || if_id_flush_o !== 1'b0) begin n_err++; $display("FAIL br_alu_stall: got pc=%0b flush=%0b want 0/0", pc_write_o, if_id_flush_o); end
        step(); sample();
        n_vec++; if (pc_write_o !== 1'b1 || fwd_br_a_o !== 1'b1 || if_id_flush_o !== 1'b1) begin n_err++; $display("FAIL br_alu_resolve: got pc=%0b fbr=%0b flush=%0b want 1/1/1", pc_write_o, fwd_br_a_o, if_id_flush_o); end
        step(); idle(); sample();
        n_vec++; if (stall_cnt_o !== 16'd1) begin n_err++; $display("FAIL br_alu_cnt: got %0d want 1", stall_cnt_o); end
        step();

        apply_reset();
        drive(1, 3, 1, 0, 0, 7, 1, 1, 0, 0, 0);            // lw x7,0(x3)
        sample(); step();
        drive(1, 7, 1, 0, 1, 0, 0, 0, 0, 1, 1);
        sample();
        n_vec++; if (pc_write_o !== 1'b0) begin n_err++; $display("FAIL br_ld_stall1: got %0b want 0", pc_write_o); end
        step(); sample();
        n_vec++; if (pc_write_o !== 1'b0 || if_id_flush_o !== 1'b0) begin n_err++; $display("FAIL br_ld_stall2: got pc=%0b flush=%0b want 0/0", pc_write_o, if_id_flush_o); end
        step(); sample();
        n_vec++; if (pc_write_o !== 1'b1 || if_id_flush_o !== 1'b1 || fwd_br_a_o !== 1'b0) begin n_err++; $display("FAIL br_ld_resolve: got pc=%0b flush=%0b fbr=%0b want 1/1/0", pc_write_o, if_id_flush_o, fwd_br_a_o); end
        step(); idle(); sample();
        n_vec++; if (stall_cnt_o !== 16'd2) begin n_err++; $display("FAIL br_ld_cnt: got %0d want 2", stall_cnt_o); end
        step();
    endtask

    task automatic test_multicycle();
        int busy_cycles;
        bit held, chk, go_idle, eb;
        busy_cycles = MC ? MUL_LAT - 1 : 0;
        apply_reset();
        drive(1, 1, 1, 2, 1, 8, 1, 0, 1, 0, 0);            // mul x8,x1,x2
        sample();
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL mc_pre_busy: got %0b want 0", busy_o); end
        step();
        drive(1, 8, 1, 4, 1, 9, 1, 0, 0, 0, 0);            // add x9,x8,x4
        held = 1'b1;
        chk  = 1'b0;
        for (int c = 0; c <= MUL_LAT; c++) begin
            sample();
            if (chk) begin
                n_vec++; if (fwd_a_o !== 2'b10) begin n_err++; $display("FAIL mc_add_in_e: got %b want 10", fwd_a_o); end
                chk = 1'b0;
            end
            eb = (c < busy_cycles);
            n_vec++; if (busy_o !== eb || ex_mem_bubble_o !== eb) begin n_err++; $display("FAIL mc_busy c%0d: got busy=%0b exb=%0b want %0b", c, busy_o, ex_mem_bubble_o, eb); end
            n_vec++; if (pc_write_o !== !eb) begin n_err++; $display("FAIL mc_pcw c%0d: got %0b want %0b", c, pc_write_o, !eb); end
            go_idle = !eb && held;
            if (go_idle) begin
                held = 1'b0;
                chk  = 1'b1;
            end
            step();
            if (go_idle) idle();
        end
        sample();
        n_vec++; if (stall_cnt_o !== CNT_W'(busy_cycles)) begin n_err++; $display("FAIL mc_stall_cnt: got %0d want %0d", stall_cnt_o, busy_cycles); end
        step();
    endtask

    task automatic test_x0();
        apply_reset();
        drive(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0);            // addi x0,x1,imm
        sample(); step();
        drive(1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0);            // add x6,x0,x0
        sample();
        n_vec++; if (pc_write_o !== 1'b1) begin n_err++; $display("FAIL x0_no_stall: got %0b want 1", pc_write_o); end
        step(); idle(); sample();
        n_vec++; if (fwd_a_o !== 2'b00 || fwd_b_o !== 2'b00) begin n_err++; $display("FAIL x0_fwd: got %b/%b want 00/00", fwd_a_o, fwd_b_o); end
        step();
        drive(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);            // lw x0,0(x1)
        sample(); step();
        drive(1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0);
        sample();
        n_vec++; if (pc_write_o !== 1'b1 || id_ex_bubble_o !== 1'b0) begin n_err++; $display("FAIL x0_load_use: got pc=%0b bub=%0b want 1/0", pc_write_o, id_ex_bubble_o); end
        step(); idle(); sample(); step();
    endtask

    task automatic test_reset_mid_busy();
        apply_reset();
        drive(1, 1, 1, 2, 1, 8, 1, 0, 1, 0, 0);            // mul x8,x1,x2
        sample(); step();
        idle(); sample(); step();
        sample();
        n_vec++; if (busy_o !== MC) begin n_err++; $display("FAIL rst_busy_before: got %0b want %0b", busy_o, MC); end
        #2;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        n_vec++; if (busy_o !== 1'b0 || ex_mem_bubble_o !== 1'b0) begin n_err++; $display("FAIL rst_busy_clear: got busy=%0b exb=%0b want 0/0", busy_o, ex_mem_bubble_o); end
        n_vec++; if (pc_write_o !== 1'b1) begin n_err++; $display("FAIL rst_pc_write: got %0b want 1", pc_write_o); end
        n_vec++; if (stall_cnt_o !== '0) begin n_err++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt_o); end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        drive(1, 8, 1, 8, 1, 1, 1, 0, 0, 0, 0);            // add x1,x8,x8
        sample();
        n_vec++; if (pc_write_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL rst_first_instr: got pc=%0b busy=%0b want 1/0", pc_write_o, busy_o); end
        step(); idle(); sample(); step();
    endtask

    task automatic test_random();
        bit hold, kill;
        int v, br, wr, ld;
        apply_reset();
        hold = 1'b0;
        kill = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (kill) begin
                idle();
            end else if (!hold) begin
                v  = ($urandom_range(0, 3) != 0);
                br = ($urandom_range(0, 5) == 0);
                wr = br ? 0 : $urandom_range(0, 1);
                ld = wr && ($urandom_range(0, 2) == 0);
                if (v == 0) idle();
                else drive(1, $urandom_range(0, 3), br ? 1 : $urandom_range(0, 1),
                           $urandom_range(0, 3), br ? 1 : $urandom_range(0, 1),
                           $urandom_range(0, 3), wr, ld,
                           (!ld && $urandom_range(0, 5) == 0), br, $urandom_range(0, 1));
            end
            sample();
            n_vec++; if (pc_write_o !== e_pcw) begin n_err++; $display("FAIL rnd_pcw @%0d: got %0b want %0b", i, pc_write_o, e_pcw); end
            n_vec++; if (if_id_write_o !== e_pcw) begin n_err++; $display("FAIL rnd_ifid @%0d: got %0b want %0b", i, if_id_write_o, e_pcw); end
            n_vec++; if (if_id_flush_o !== e_flush) begin n_err++; $display("FAIL rnd_flush @%0d: got %0b want %0b", i, if_id_flush_o, e_flush); end
            n_vec++; if (id_ex_bubble_o !== e_idb) begin n_err++; $display("FAIL rnd_idb @%0d: got %0b want %0b", i, id_ex_bubble_o, e_idb); end
            n_vec++; if (ex_mem_bubble_o !== e_exb) begin n_err++; $display("FAIL rnd_exb @%0d: got %0b want %0b", i, ex_mem_bubble_o, e_exb); end
            n_vec++; if (busy_o !== e_busy) begin n_err++; $display("FAIL rnd_busy @%0d: got %0b want %0b", i, busy_o, e_busy); end
            n_vec++; if (fwd_a_o !== 2'(e_fa)) begin n_err++; $display("FAIL rnd_fwd_a @%0d: got %b want %0d", i, fwd_a_o, e_fa); end
            n_vec++; if (fwd_b_o !== 2'(e_fb)) begin n_err++; $display("FAIL rnd_fwd_b @%0d: got %b want %0d", i, fwd_b_o, e_fb); end
            n_vec++; if (fwd_br_a_o !== e_fba) begin n_err++; $display("FAIL rnd_fbr_a @%0d: got %0b want %0b", i, fwd_br_a_o, e_fba); end
            n_vec++; if (fwd_br_b_o !== e_fbb) begin n_err++; $display("FAIL rnd_fbr_b @%0d: got %0b want %0b", i, fwd_br_b_o, e_fbb); end
            n_vec++; if (stall_cnt_o !== CNT_W'(e_sc)) begin n_err++; $display("FAIL rnd_stall_cnt @%0d: got %0d want %0d", i, stall_cnt_o, e_sc); end
            hold = !e_pcw;
            kill = e_flush;
            step();
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        idle();
        model_reset();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_multicycle();
        test_x0();
        test_reset_mid_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
